arc4_key_search: RTL and testbench
==================================

// Module: arc4_key_search
// PURPOSE
//  Brute-force key-search controller that sits upstream of arc4 and drives its en/key inputs.
//  For each candidate key it launches one arc4 decryption and snoops arc4's plaintext-memory writes.
//  A key is accepted when every plaintext byte after the length byte is printable ASCII.
//  Reports the first accepted key, or "not found" once the key range is exhausted.
// PARAMETERS
//  KEY_START  24'h000000  first candidate key
//  KEY_LAST   24'hFFFFFF  last candidate key (inclusive)
//  CHAR_LO    8'h20       lowest printable byte (inclusive)
//  CHAR_HI    8'h7E       highest printable byte (inclusive)
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst_n      in   1   synchronous active-low reset
//  en         in   1   start request; honoured only while rdy=1
//  rdy        out  1   1 = idle, ready to accept en
//  key        out  24  last accepted key; valid when key_valid=1
//  key_valid  out  1   1 = key holds an accepted key
//  a4_en      out  1   one-cycle start pulse to arc4
//  a4_key     out  24  candidate key to arc4; held stable from a4_en until arc4 finishes
//  a4_rdy     in   1   arc4 rdy
//  pt_addr    in   8   snoop of arc4 pt_addr
//  pt_wrdata  in   8   snoop of arc4 pt_wrdata
//  pt_wren    in   1   snoop of arc4 pt_wren
// BEHAVIOUR
//  Reset values (rst_n=0 at a clk edge)
//   - state=IDLE, rdy=1, key_valid=0, key=0, a4_en=0, a4_key=KEY_START, bad=0, busy_seen=0.
//   - Reset mid-search abandons the search immediately; next cycle is IDLE with rdy=1.
//  Handshake
//   - en with rdy=1: rdy=0 and key_valid=0 on the next cycle; cand=KEY_START.
//   - en while rdy=0: ignored.
//   - a4_en is pulsed for exactly 1 cycle, only while a4_rdy=1.
//  States
//   - IDLE: rdy=1. On en, go to LAUNCH.
//   - LAUNCH: wait for a4_rdy=1. Then a4_en=1 and a4_key=cand; clear bad and busy_seen; go to RUN.
//   - RUN: set busy_seen when a4_rdy=0. When busy_seen=1 and a4_rdy=1, go to JUDGE.
//     - Any pt_wren=1 with pt_addr!=0 and (pt_wrdata<CHAR_LO or pt_wrdata>CHAR_HI) sets bad.
//     - The pt_addr==0 write is the length byte and is never checked.
//     - A write in the same cycle that a4_rdy rises is still checked before JUDGE.
//   - JUDGE (1 cycle):
//     - bad=0: key=cand, key_valid=1, go to IDLE.
//     - bad=1 and cand==KEY_LAST: key_valid=0, go to IDLE (not found).
//     - otherwise: cand=cand+1 (24-bit, no wrap past KEY_LAST), go to LAUNCH.
//  Latency
//   - Per candidate: arc4 run time + 3 cycles (LAUNCH, the a4_rdy-rise edge, JUDGE).
//   - rdy returns 1 on the cycle after JUDGE.
//  Edge cases
//   - KEY_START==KEY_LAST: exactly one attempt.
//   - A message of length 0 (only the pt[0] write) is accepted.
//   - Once set, bad is sticky until the next LAUNCH.
// STRUCTURE
//  - arc4_pkg holds: state enum {IDLE, LAUNCH, RUN, JUDGE}, CHAR_LO/CHAR_HI defaults, KEY_W=24.
//  - One sub-module, arc4_pt_checker: combinational printable-byte test plus the sticky bad flag
//    (clear/snoop inputs).
//  - Top level holds the FSM and the candidate counter.
// TESTING
//  Bench uses a behavioural arc4 model: rdy drops 1 cycle after en, then 20 busy cycles,
//  then writes pt[0..4].
//  1. Reset: after rst_n=0 -> rdy=1, key_valid=0, a4_en=0, key=24'h0.
//  2. Model writes 8'h41 for key 24'h000003 and 8'h07 for other keys
//     -> exactly 4 a4_en pulses, then key=24'h000003, key_valid=1, rdy=1.
//  3. Good key writes pt[0]=8'h05 (non-printable length byte)
//     -> key still accepted on the first attempt.
//  4. KEY_LAST=24'h000005, no good key -> 6 a4_en pulses, key_valid=0, rdy=1.
//  5. Model writes 8'h7F to pt_addr 4 in the cycle a4_rdy rises -> key rejected, next key launched.
//  6. rst_n=0 for 1 cycle during RUN of key 2 -> rdy=1, a4_en=0.
//     A new en then restarts at KEY_START (first a4_key=24'h000000).

Source files
------------

// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arc4_pkg
// Description : Shared types and constants for the arc4 key-search slice:
//               controller state encoding, key width, printable-byte window.
// Revision    : 1.0 - initial release
// ============================================================================
package arc4_pkg;

  localparam int KEY_W = 24;

  localparam logic [7:0] CHAR_LO_DEFAULT = 8'h20;
  localparam logic [7:0] CHAR_HI_DEFAULT = 8'h7E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    JUDGE  = 2'd3
  } state_t;

  // True when b lies inside the inclusive window [lo, hi].
  function automatic logic is_printable(input logic [7:0] b,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arc4_pt_checker.sv
`default_nettype none
// ============================================================================
// Module      : arc4_pt_checker
// Description : Snoops arc4 plaintext writes and raises a sticky "bad" flag
//               on any non-printable byte outside the length slot (addr 0).
// Revision    : 1.0 - initial release
// ============================================================================
module arc4_pt_checker
  import arc4_pkg::*;
#(
  parameter logic [7:0] CHAR_LO = CHAR_LO_DEFAULT,
  parameter logic [7:0] CHAR_HI = CHAR_HI_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       snoop,
  input  logic       pt_wren,
  input  logic [7:0] pt_addr,
  input  logic [7:0] pt_wrdata,
  output logic       bad
);

  logic w_byte_bad;
  logic r_bad;

  // A write flags the candidate only while snooping, and never for the length byte.
  always_comb begin
    w_byte_bad = 1'b0;
    if (snoop && pt_wren && (pt_addr != 8'h00)) begin
      w_byte_bad = !is_printable(pt_wrdata, CHAR_LO, CHAR_HI);
    end
  end

  // Sticky flag: once set it holds until the next launch clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bad <= 1'b0;
    end else if (clear) begin
      r_bad <= 1'b0;
    end else if (w_byte_bad) begin
      r_bad <= 1'b1;
    end
  end

  assign bad = r_bad;

endmodule
`default_nettype wire

// File: rtl/arc4_key_search.sv
`default_nettype none
// ============================================================================
// Module      : arc4_key_search
// Description : Brute-force key-search controller in front of arc4. Launches
//               one decryption per candidate key, judges the plaintext and
//               reports the first key whose message is fully printable.
// Revision    : 1.0 - initial release
// ============================================================================
module arc4_key_search
  import arc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_LAST  = 24'hFFFFFF,
  parameter logic [7:0]       CHAR_LO   = CHAR_LO_DEFAULT,
  parameter logic [7:0]       CHAR_HI   = CHAR_HI_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             a4_en,
  output logic [KEY_W-1:0] a4_key,
  input  logic             a4_rdy,
  input  logic [7:0]       pt_addr,
  input  logic [7:0]       pt_wrdata,
  input  logic             pt_wren
);

  state_t           r_state;
  state_t           w_next_state;
  logic [KEY_W-1:0] r_cand;
  logic [KEY_W-1:0] r_key;
  logic             r_key_valid;
  logic             r_busy_seen;
  logic             w_launch;
  logic             w_bad;
  logic             w_snoop;

  assign w_snoop = (r_state == RUN);

  arc4_pt_checker #(
    .CHAR_LO (CHAR_LO),
    .CHAR_HI (CHAR_HI)
  ) u_pt_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_launch),
    .snoop     (w_snoop),
    .pt_wren   (pt_wren),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .bad       (w_bad)
  );

  // Next-state logic; the launch strobe is only raised while arc4 is idle.
  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        if (a4_rdy) begin
          w_launch     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        // arc4 must first be seen busy so the rdy level left over from the
        // launch cycle is not mistaken for completion.
        if (r_busy_seen && a4_rdy) begin
          w_next_state = JUDGE;
        end
      end
      JUDGE: begin
        if (!w_bad || (r_cand == KEY_LAST)) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = LAUNCH;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register plus candidate counter, busy tracking and result latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cand      <= KEY_START;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_busy_seen <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_cand      <= KEY_START;
            r_key_valid <= 1'b0;
          end
        end
        LAUNCH: begin
          if (a4_rdy) begin
            r_busy_seen <= 1'b0;
          end
        end
        RUN: begin
          if (!a4_rdy) begin
            r_busy_seen <= 1'b1;
          end
        end
        JUDGE: begin
          if (!w_bad) begin
            r_key       <= r_cand;
            r_key_valid <= 1'b1;
          end else if (r_cand == KEY_LAST) begin
            r_key_valid <= 1'b0;
          end else begin
            r_cand <= r_cand + KEY_W'(1);
          end
        end
        default: begin
          r_busy_seen <= 1'b0;
        end
      endcase
    end
  end

  // The candidate register doubles as the arc4 key: it only changes in
  // JUDGE, so it is stable from the launch pulse until arc4 finishes.
  assign a4_key    = r_cand;
  assign a4_en     = w_launch;
  assign rdy       = (r_state == IDLE);
  assign key       = r_key;
  assign key_valid = r_key_valid;

endmodule
`default_nettype wire

// File: tb/tb_arc4_key_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_arc4_key_search
// Description : Self-checking bench for arc4_key_search with a behavioural
//               arc4 peer and a reference key-search model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arc4_key_search;

  localparam logic [23:0] KS = 24'h000000;
  localparam logic [23:0] KL = 24'h000005;
  localparam int          BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic        key_valid;
  logic        a4_en;
  logic [23:0] a4_key;
  logic        a4_rdy;
  logic [7:0]  pt_addr = 8'h00;
  logic [7:0]  pt_wrdata = 8'h00;
  logic        pt_wren = 1'b0;

  logic        m_rdy = 1'b1;
  bit          m_overlap = 1'b0;
  logic [7:0]  msg [0:7][0:4];
  logic [23:0] launched [$];
  int          en_count = 0;
  int          en_viol = 0;

  int total = 0;
  int bad_cnt = 0;
  int e_base = 0;
  int l_base = 0;

  always #5 clk = ~clk;

  assign a4_rdy = m_rdy;

  arc4_key_search #(
    .KEY_START (KS),
    .KEY_LAST  (KL),
    .CHAR_LO   (8'h20),
    .CHAR_HI   (8'h7E)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .key_valid (key_valid),
    .a4_en     (a4_en),
    .a4_key    (a4_key),
    .a4_rdy    (a4_rdy),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  // Counts launch pulses and any pulse raised while arc4 is busy.
  always @(negedge clk) begin
    if (a4_en === 1'b1) begin
      en_count++;
      if (m_rdy !== 1'b1) en_viol++;
    end
  end

  // Behavioural arc4: rdy drops after the en edge, 20 busy cycles, then pt[0..4].
  always begin : arc4_model
    logic [23:0] cur;
    @(negedge clk);
    if (a4_en === 1'b1 && m_rdy === 1'b1) begin
      cur = a4_key;
      launched.push_back(cur);
      @(posedge clk); #2;
      m_rdy = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      for (int a = 0; a < 5; a++) begin
        pt_wren   = 1'b1;
        pt_addr   = 8'(a);
        pt_wrdata = msg[cur[2:0]][a];
        if (a == 4 && m_overlap) m_rdy = 1'b1;
        @(posedge clk); #2;
      end
      pt_wren = 1'b0;
      pt_addr = 8'h00;
      m_rdy   = 1'b1;
    end
  end

  // Reference: scan keys in order, accept the first whose bytes 1..4 are printable.
  task automatic ref_search(output bit found, output int k_found, output int n_launch);
    found = 1'b0;
    k_found = 0;
    n_launch = 0;
    for (int k = int'(KS); k <= int'(KL); k++) begin
      bit ok;
      n_launch++;
      ok = 1'b1;
      for (int a = 1; a < 5; a++)
        if (msg[k][a] < 8'h20 || msg[k][a] > 8'h7E) ok = 1'b0;
      if (ok) begin
        found = 1'b1;
        k_found = k;
        break;
      end
    end
  endtask

  task automatic fill_all(input logic [7:0] len_b, input logic [7:0] body);
    for (int k = 0; k < 8; k++) begin
      msg[k][0] = len_b;
      for (int a = 1; a < 5; a++) msg[k][a] = body;
    end
  endtask

  task automatic start_search(input string name);
    e_base = en_count;
    l_base = launched.size();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rdy !== 1'b0 || key_valid !== 1'b0) begin
      bad_cnt++;
      $display("FAIL %s start: rdy=%b key_valid=%b required rdy=0 key_valid=0", name, rdy, key_valid);
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < BUDGET && !done; i++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad_cnt++;
      $display("FAIL %s timeout: rdy=%b after %0d cycles, required 1", name, rdy, BUDGET);
    end
  endtask

  task automatic check_outcome(input string name);
    bit found;
    int k_found;
    int n_launch;
    int n_seen;
    ref_search(found, k_found, n_launch);
    n_seen = en_count - e_base;
    total++;
    if (key_valid !== found) begin
      bad_cnt++;
      $display("FAIL %s key_valid: got %b required %b", name, key_valid, found);
    end
    if (found) begin
      total++;
      if (key !== 24'(k_found)) begin
        bad_cnt++;
        $display("FAIL %s key: got %h required %h", name, key, 24'(k_found));
      end
    end
    total++;
    if (n_seen != n_launch) begin
      bad_cnt++;
      $display("FAIL %s launches: got %0d required %0d", name, n_seen, n_launch);
    end
    total++;
    if (launched.size() - l_base != n_launch) begin
      bad_cnt++;
      $display("FAIL %s accepted launches: got %0d required %0d", name, launched.size() - l_base, n_launch);
    end else begin
      for (int i = 0; i < n_launch; i++) begin
        total++;
        if (launched[l_base + i] !== KS + 24'(i)) begin
          bad_cnt++;
          $display("FAIL %s a4_key[%0d]: got %h required %h", name, i, launched[l_base + i], KS + 24'(i));
        end
      end
    end
    total++;
    if (rdy !== 1'b1 || en_viol != 0) begin
      bad_cnt++;
      $display("FAIL %s idle: rdy=%b busy-launches=%0d required rdy=1 busy-launches=0", name, rdy, en_viol);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rdy !== 1'b1 || key_valid !== 1'b0 || a4_en !== 1'b0 || key !== 24'h0 || a4_key !== KS) begin
      bad_cnt++;
      $display("FAIL reset: rdy=%b kv=%b a4_en=%b key=%h a4_key=%h required 1 0 0 000000 %h",
               rdy, key_valid, a4_en, key, a4_key, KS);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fourth_key();
    fill_all(8'h04, 8'h07);
    for (int a = 1; a < 5; a++) msg[3][a] = 8'h41;
    start_search("fourth_key");
    wait_done("fourth_key");
    check_outcome("fourth_key");
  endtask

  task automatic test_length_byte();
    fill_all(8'h05, 8'h41);
    start_search("length_byte");
    wait_done("length_byte");
    check_outcome("length_byte");
  endtask

  task automatic test_not_found();
    fill_all(8'h04, 8'h80);
    msg[2][3] = 8'h1F;
    msg[4][1] = 8'h7F;
    start_search("not_found");
    wait_done("not_found");
    check_outcome("not_found");
  endtask

  task automatic test_overlap_write();
    fill_all(8'h04, 8'h7E);
    msg[0][4] = 8'h7F;
    msg[1][1] = 8'h20;
    m_overlap = 1'b1;
    start_search("overlap_write");
    wait_done("overlap_write");
    check_outcome("overlap_write");
    m_overlap = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int good_idx;
      good_idx = int'($urandom_range(0, 6));
      for (int k = 0; k < 8; k++) begin
        msg[k][0] = 8'($urandom);
        for (int a = 1; a < 5; a++) begin
          case ($urandom_range(0, 3))
            0:       msg[k][a] = 8'h20;
            1:       msg[k][a] = 8'h7E;
            default: msg[k][a] = 8'(32 + $urandom_range(0, 94));
          endcase
        end
        if (k != good_idx && $urandom_range(0, 3) != 0) begin
          int pos;
          pos = int'($urandom_range(1, 4));
          case ($urandom_range(0, 3))
            0:       msg[k][pos] = 8'h1F;
            1:       msg[k][pos] = 8'h7F;
            2:       msg[k][pos] = 8'($urandom_range(0, 31));
            default: msg[k][pos] = 8'($urandom_range(127, 255));
          endcase
        end
      end
      start_search("random");
      wait_done("random");
      check_outcome("random");
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    fill_all(8'h04, 8'h00);
    start_search("reset_mid");
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (en_count - e_base >= 3) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad_cnt++;
      $display("FAIL reset_mid third launch: launches=%0d required 3", en_count - e_base);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rdy !== 1'b1 || a4_en !== 1'b0 || key_valid !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_mid state: rdy=%b a4_en=%b kv=%b required 1 0 0", rdy, a4_en, key_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_search("restart");
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (launched.size() > l_base) seen = 1'b1;
    end
    total++;
    if (!seen || launched[l_base] !== KS) begin
      bad_cnt++;
      $display("FAIL restart first a4_key: seen=%b key=%h required %h", seen, seen ? launched[l_base] : 24'hx, KS);
    end
    wait_done("restart");
    check_outcome("restart");
  endtask

  initial begin
    fill_all(8'h00, 8'h00);
    test_reset();
    test_fourth_key();
    test_length_byte();
    test_not_found();
    test_overlap_write();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
